// File: rtl/vdp_bus_pkg.sv
// vdp_bus_pkg: entry layout shared by the VDP posted-write buffer and its storage array.
package vdp_bus_pkg;

    localparam int ENT_W         = 13;
    localparam int ENT_WDATA_LSB = 0;
    localparam int ENT_WDATA_MSB = 7;
    localparam int ENT_ADDR_LSB  = 8;
    localparam int ENT_ADDR_MSB  = 10;
    localparam int ENT_WRITE     = 11;
    localparam int ENT_IOREQ     = 12;

    typedef logic [ENT_W-1:0] entry_t;

    // Reads carry no payload, so their data field is forced to zero.
    function automatic entry_t pack_entry(
        input logic       ioreq,
        input logic       write,
        input logic [2:0] addr,
        input logic [7:0] wdata
    );
        return {ioreq, write, addr, write ? wdata : 8'h00};
    endfunction

endpackage

// File: rtl/vdp_bus_fifo_mem.sv
// vdp_bus_fifo_mem: DEPTH x ENT_W register array, synchronous write, asynchronous read.
module vdp_bus_fifo_mem
    import vdp_bus_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  entry_t        wr_data,
    input  logic [AW-1:0] rd_addr,
    output entry_t        rd_data
);

    entry_t mem_q [DEPTH];
    entry_t mem_d [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        always_comb begin
            mem_d[g] = (wr_en && wr_addr == AW'(g)) ? wr_data : mem_q[g];
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) mem_q[g] <= '0;
            else          mem_q[g] <= mem_d[g];
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/vdp_bus_buffer.sv
// vdp_bus_buffer: posted-write request buffer from the MSX slot bus to the VDP port,
// a circular store followed by one output register, with a single outstanding read.
module vdp_bus_buffer
    import vdp_bus_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int LEVEL_W = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         bus_address,
    input  logic               bus_ioreq,
    input  logic               bus_write,
    input  logic               bus_valid,
    output logic               bus_ready,
    input  logic [7:0]         bus_wdata,
    output logic [7:0]         bus_rdata,
    output logic               bus_rdata_en,
    output logic [2:0]         vdp_address,
    output logic               vdp_ioreq,
    output logic               vdp_write,
    output logic               vdp_valid,
    input  logic               vdp_ready,
    output logic [7:0]         vdp_wdata,
    input  logic [7:0]         vdp_rdata,
    input  logic               vdp_rdata_en,
    output logic [LEVEL_W-1:0] fifo_level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0] count_q, count_d;
    logic               rd_pending_q, rd_pending_d;
    logic               out_valid_q, out_valid_d;
    entry_t             out_ent_q, out_ent_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               rdata_en_q, rdata_en_d;

    logic   full, push, out_pop, load, rd_return;
    entry_t head;

    // Both blocking terms are registered, so ready never depends on bus_valid.
    assign full      = count_q == LEVEL_W'(DEPTH);
    assign bus_ready = !full && !rd_pending_q;
    assign push      = bus_valid && bus_ready;
    assign out_pop   = out_valid_q && vdp_ready;
    assign load      = (count_q != '0) && (!out_valid_q || out_pop);
    assign rd_return = vdp_rdata_en && rd_pending_q;

    vdp_bus_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (pack_entry(bus_ioreq, bus_write, bus_address, bus_wdata)),
        .rd_addr (rd_ptr_q),
        .rd_data (head)
    );

    always_comb begin
        wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d     = load ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d      = count_q + LEVEL_W'(push) - LEVEL_W'(load);
        out_valid_d  = load ? 1'b1 : (out_pop ? 1'b0 : out_valid_q);
        out_ent_d    = load ? head : out_ent_q;
        rd_pending_d = (push && !bus_write) ? 1'b1 : (rd_return ? 1'b0 : rd_pending_q);
        rdata_d      = rd_return ? vdp_rdata : rdata_q;
        rdata_en_d   = rd_return;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rd_pending_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_ent_q    <= '0;
            rdata_q      <= 8'h00;
            rdata_en_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rd_pending_q <= rd_pending_d;
            out_valid_q  <= out_valid_d;
            out_ent_q    <= out_ent_d;
            rdata_q      <= rdata_d;
            rdata_en_q   <= rdata_en_d;
        end
    end

    assign vdp_valid    = out_valid_q;
    assign vdp_address  = out_ent_q[ENT_ADDR_MSB:ENT_ADDR_LSB];
    assign vdp_ioreq    = out_ent_q[ENT_IOREQ];
    assign vdp_write    = out_ent_q[ENT_WRITE];
    assign vdp_wdata    = out_ent_q[ENT_WDATA_MSB:ENT_WDATA_LSB];
    assign bus_rdata    = rdata_q;
    assign bus_rdata_en = rdata_en_q;
    assign fifo_level   = count_q;

endmodule

// File: tb/tb_vdp_bus_buffer.sv
// tb_vdp_bus_buffer: randomized and directed checks of vdp_bus_buffer against an
// in-order request stream model kept in queues.
module tb_vdp_bus_buffer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] bus_address = '0;
    logic       bus_ioreq = 1'b0;
    logic       bus_write = 1'b0;
    logic       bus_valid = 1'b0;
    logic       bus_ready;
    logic [7:0] bus_wdata = '0;
    logic [7:0] bus_rdata;
    logic       bus_rdata_en;
    logic [2:0] vdp_address;
    logic       vdp_ioreq;
    logic       vdp_write;
    logic       vdp_valid;
    logic       vdp_ready = 1'b0;
    logic [7:0] vdp_wdata;
    logic [7:0] vdp_rdata = '0;
    logic       vdp_rdata_en = 1'b0;
    logic [2:0] fifo_level;

    int total = 0;
    int bad = 0;

    logic [12:0] acc_q[$];
    logic [12:0] obs_q[$];
    int pulses = 0;
    int max_level = 0;

    vdp_bus_buffer #(.DEPTH(4), .LEVEL_W(3)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus_address  (bus_address),
        .bus_ioreq    (bus_ioreq),
        .bus_write    (bus_write),
        .bus_valid    (bus_valid),
        .bus_ready    (bus_ready),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .bus_rdata_en (bus_rdata_en),
        .vdp_address  (vdp_address),
        .vdp_ioreq    (vdp_ioreq),
        .vdp_write    (vdp_write),
        .vdp_valid    (vdp_valid),
        .vdp_ready    (vdp_ready),
        .vdp_wdata    (vdp_wdata),
        .vdp_rdata    (vdp_rdata),
        .vdp_rdata_en (vdp_rdata_en),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout reached before summary");
        $fatal(1);
    end

    // Inputs change at posedge+1, so the negedge view is what the next edge will see.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus_valid && bus_ready)
                acc_q.push_back({bus_ioreq, bus_write, bus_address, bus_write ? bus_wdata : 8'h00});
            if (vdp_valid && vdp_ready)
                obs_q.push_back({vdp_ioreq, vdp_write, vdp_address, vdp_wdata});
            if (bus_rdata_en) pulses++;
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic io, input logic wr, input logic [2:0] a, input logic [7:0] d);
        bus_valid = v; bus_ioreq = io; bus_write = wr; bus_address = a; bus_wdata = d;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        @(negedge clk);
        total++; if (bus_ready !== 1'b1) begin bad++; $display("FAIL reset_bus_ready got=%0h exp=1", bus_ready); end
        total++; if (bus_rdata !== 8'h00) begin bad++; $display("FAIL reset_bus_rdata got=%0h exp=0", bus_rdata); end
        total++; if (bus_rdata_en !== 1'b0) begin bad++; $display("FAIL reset_bus_rdata_en got=%0h exp=0", bus_rdata_en); end
        total++; if (vdp_valid !== 1'b0) begin bad++; $display("FAIL reset_vdp_valid got=%0h exp=0", vdp_valid); end
        total++; if ({vdp_ioreq, vdp_write, vdp_address, vdp_wdata} !== 13'h0) begin bad++; $display("FAIL reset_vdp_fields got=%0h exp=0", {vdp_ioreq, vdp_write, vdp_address, vdp_wdata}); end
        total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL reset_fifo_level got=%0d exp=0", fifo_level); end
        tick();
    endtask

    task automatic test_single_write();
        vdp_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 3'd0, 8'h5A);
        tick();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        @(negedge clk);
        total++; if (vdp_valid !== 1'b0) begin bad++; $display("FAIL single_n1_valid got=%0h exp=0", vdp_valid); end
        total++; if (fifo_level !== 3'd1) begin bad++; $display("FAIL single_n1_level got=%0d exp=1", fifo_level); end
        tick();
        @(negedge clk);
        total++; if (vdp_valid !== 1'b1) begin bad++; $display("FAIL single_n2_valid got=%0h exp=1", vdp_valid); end
        total++; if ({vdp_write, vdp_address, vdp_wdata} !== {1'b1, 3'd0, 8'h5A}) begin bad++; $display("FAIL single_n2_fields got=%0h exp=%0h", {vdp_write, vdp_address, vdp_wdata}, {1'b1, 3'd0, 8'h5A}); end
        total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL single_n2_level got=%0d exp=0", fifo_level); end
        tick();
        @(negedge clk);
        total++; if (vdp_valid !== 1'b0) begin bad++; $display("FAIL single_n3_valid got=%0h exp=0", vdp_valid); end
        tick();
    endtask

    task automatic test_fill();
        vdp_ready = 1'b0;
        obs_q.delete(); acc_q.delete();
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 1'b1, 1'b1, 3'd2, 8'(i));
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        @(negedge clk);
        total++; if (bus_ready !== 1'b0) begin bad++; $display("FAIL fill_ready got=%0h exp=0", bus_ready); end
        total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL fill_level got=%0d exp=4", fifo_level); end
        tick();
        drive(1'b1, 1'b1, 1'b1, 3'd2, 8'hEE);
        repeat (3) tick();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        total++; if (acc_q.size() !== 5) begin bad++; $display("FAIL fill_accepted got=%0d exp=5", acc_q.size()); end
        total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL fill_stalled got=%0d exp=0", obs_q.size()); end
        vdp_ready = 1'b1;
        repeat (5) tick();
        total++; if (obs_q.size() !== 5) begin bad++; $display("FAIL fill_drain_count got=%0d exp=5", obs_q.size()); end
        for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== {1'b1, 1'b1, 3'd2, 8'(i + 1)}) begin
                bad++; $display("FAIL fill_order[%0d] got=%0h exp=%0h", i, obs_q[i], {1'b1, 1'b1, 3'd2, 8'(i + 1)});
            end
        end
        total++; if (vdp_valid !== 1'b0) begin bad++; $display("FAIL fill_idle got=%0h exp=0", vdp_valid); end
        total++; if (bus_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_back got=%0h exp=1", bus_ready); end
    endtask

    task automatic test_read_order();
        logic [12:0] exp_e[3];
        exp_e[0] = {1'b1, 1'b1, 3'd0, 8'h11};
        exp_e[1] = {1'b1, 1'b1, 3'd0, 8'h22};
        exp_e[2] = {1'b1, 1'b0, 3'd1, 8'h00};
        vdp_ready = 1'b0;
        obs_q.delete(); acc_q.delete(); pulses = 0;
        drive(1'b1, 1'b1, 1'b1, 3'd0, 8'h11); tick();
        drive(1'b1, 1'b1, 1'b1, 3'd0, 8'h22); tick();
        drive(1'b1, 1'b1, 1'b0, 3'd1, 8'hFF); tick();
        drive(1'b1, 1'b1, 1'b1, 3'd3, 8'h33);
        @(negedge clk);
        total++; if (bus_ready !== 1'b0) begin bad++; $display("FAIL rd_blocks_ready got=%0h exp=0", bus_ready); end
        tick(); tick();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        vdp_ready = 1'b1;
        for (int c = 0; c < 20 && obs_q.size() < 3; c++) tick();
        total++; if (obs_q.size() !== 3) begin bad++; $display("FAIL rd_stream_count got=%0d exp=3", obs_q.size()); end
        for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_e[i]) begin bad++; $display("FAIL rd_stream[%0d] got=%0h exp=%0h", i, obs_q[i], exp_e[i]); end
        end
        total++; if (acc_q.size() !== 3) begin bad++; $display("FAIL rd_no_accept_pending got=%0d exp=3", acc_q.size()); end
        total++; if (bus_ready !== 1'b0) begin bad++; $display("FAIL rd_wait_ready got=%0h exp=0", bus_ready); end
        vdp_rdata = 8'hC3; vdp_rdata_en = 1'b1;
        tick();
        vdp_rdata_en = 1'b0; vdp_rdata = 8'h00;
        @(negedge clk);
        total++; if (bus_rdata_en !== 1'b1) begin bad++; $display("FAIL rd_strobe got=%0h exp=1", bus_rdata_en); end
        total++; if (bus_rdata !== 8'hC3) begin bad++; $display("FAIL rd_data got=%0h exp=c3", bus_rdata); end
        total++; if (bus_ready !== 1'b1) begin bad++; $display("FAIL rd_release got=%0h exp=1", bus_ready); end
        tick();
        total++; if (bus_rdata_en !== 1'b0) begin bad++; $display("FAIL rd_strobe_len got=%0h exp=0", bus_rdata_en); end
        total++; if (pulses !== 1) begin bad++; $display("FAIL rd_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_stray();
        int p0;
        p0 = pulses;
        vdp_rdata = 8'h77; vdp_rdata_en = 1'b1;
        tick();
        vdp_rdata_en = 1'b0;
        @(negedge clk);
        total++; if (bus_rdata_en !== 1'b0) begin bad++; $display("FAIL stray_strobe got=%0h exp=0", bus_rdata_en); end
        total++; if (bus_rdata !== 8'hC3) begin bad++; $display("FAIL stray_data got=%0h exp=c3", bus_rdata); end
        tick();
        total++; if (pulses !== p0) begin bad++; $display("FAIL stray_pulses got=%0d exp=%0d", pulses, p0); end
    endtask

    task automatic test_wrap();
        logic [12:0] d[20];
        int idx;
        for (int i = 0; i < 20; i++)
            d[i] = {1'($urandom_range(0, 1)), 1'b1, 3'($urandom_range(0, 7)), 8'($urandom)};
        obs_q.delete(); acc_q.delete(); max_level = 0;
        for (int c = 0; c < 600 && acc_q.size() < 20; c++) begin
            idx = acc_q.size();
            drive(1'b1, d[idx][12], 1'b1, d[idx][10:8], d[idx][7:0]);
            vdp_ready = 1'($urandom_range(0, 1));
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        vdp_ready = 1'b1;
        for (int c = 0; c < 50 && obs_q.size() < 20; c++) tick();
        total++; if (acc_q.size() !== 20) begin bad++; $display("FAIL wrap_accepted got=%0d exp=20", acc_q.size()); end
        total++; if (obs_q.size() !== 20) begin bad++; $display("FAIL wrap_delivered got=%0d exp=20", obs_q.size()); end
        for (int i = 0; i < 20 && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== d[i]) begin bad++; $display("FAIL wrap_seq[%0d] got=%0h exp=%0h", i, obs_q[i], d[i]); end
        end
        total++; if (max_level > 4) begin bad++; $display("FAIL wrap_max_level got=%0d exp<=4", max_level); end
        total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL wrap_final_level got=%0d exp=0", fifo_level); end
    endtask

    task automatic test_mid_reset();
        int p0;
        vdp_ready = 1'b0;
        obs_q.delete();
        drive(1'b1, 1'b1, 1'b1, 3'd0, 8'hA1); tick();
        drive(1'b1, 1'b1, 1'b1, 3'd1, 8'hA2); tick();
        drive(1'b1, 1'b1, 1'b1, 3'd2, 8'hA3); tick();
        drive(1'b1, 1'b1, 1'b0, 3'd3, 8'h00); tick();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        total++; if (fifo_level !== 3'd3) begin bad++; $display("FAIL mrst_pre_level got=%0d exp=3", fifo_level); end
        total++; if (bus_ready !== 1'b0) begin bad++; $display("FAIL mrst_pre_ready got=%0h exp=0", bus_ready); end
        #2 reset_n = 1'b0;
        #1;
        total++; if (bus_ready !== 1'b1) begin bad++; $display("FAIL mrst_ready got=%0h exp=1", bus_ready); end
        total++; if (vdp_valid !== 1'b0) begin bad++; $display("FAIL mrst_valid got=%0h exp=0", vdp_valid); end
        total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL mrst_level got=%0d exp=0", fifo_level); end
        total++; if (bus_rdata !== 8'h00) begin bad++; $display("FAIL mrst_rdata got=%0h exp=0", bus_rdata); end
        total++; if ({vdp_ioreq, vdp_write, vdp_address, vdp_wdata} !== 13'h0) begin bad++; $display("FAIL mrst_fields got=%0h exp=0", {vdp_ioreq, vdp_write, vdp_address, vdp_wdata}); end
        @(posedge clk);
        #3 reset_n = 1'b1;
        p0 = pulses;
        vdp_ready = 1'b1; vdp_rdata = 8'h99; vdp_rdata_en = 1'b1;
        total++; if (bus_ready !== 1'b1) begin bad++; $display("FAIL mrst_release_ready got=%0h exp=1", bus_ready); end
        tick();
        vdp_rdata_en = 1'b0;
        repeat (5) tick();
        total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL mrst_no_issue got=%0d exp=0", obs_q.size()); end
        total++; if (pulses !== p0) begin bad++; $display("FAIL mrst_no_strobe got=%0d exp=%0d", pulses, p0); end
        total++; if (bus_rdata !== 8'h00) begin bad++; $display("FAIL mrst_rdata_after got=%0h exp=0", bus_rdata); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_fill();
        test_read_order();
        test_stray();
        test_wrap();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vdp_bus_buffer.md
# vdp_bus_buffer

Posted-write request buffer between the MSX slot bus front end (`msx_slot`) and the V9958-clone `vdp` bus port, in the 85.90908 MHz `clk85m` domain. It absorbs bursts of CPU I/O writes (OUT/OTIR to ports 98h–9Bh) so the slot side rarely waits. Reads pass through in order behind queued writes. Read data returns to the slot with one registered stage.

## Interface
Parameters:
- `DEPTH`, 4: storage entries. Power of two, range 2–16. Total capacity including the output register is DEPTH+1.
- `LEVEL_W`, 3: width of `fifo_level`. Must satisfy 2^LEVEL_W > DEPTH.

Ports:
- `clk` in 1: 85.90908 MHz clock, the only clock.
- `reset_n` in 1: asynchronous reset, active-low.
- `bus_address` in 3: upstream port offset.
- `bus_ioreq` in 1: upstream I/O request qualifier, stored per entry.
- `bus_write` in 1: 1 = write, 0 = read.
- `bus_valid` in 1: upstream request present.
- `bus_ready` out 1: request accepted this cycle when `bus_valid & bus_ready`.
- `bus_wdata` in 8: upstream write data.
- `bus_rdata` out 8: read data, registered.
- `bus_rdata_en` out 1: one-cycle strobe marking `bus_rdata` valid.
- `vdp_address` out 3: downstream port offset.
- `vdp_ioreq` out 1: downstream I/O request qualifier.
- `vdp_write` out 1: downstream write/read select.
- `vdp_valid` out 1: downstream request present.
- `vdp_ready` in 1: downstream accepts the request when `vdp_valid & vdp_ready`.
- `vdp_wdata` out 8: downstream write data.
- `vdp_rdata` in 8: downstream read data.
- `vdp_rdata_en` in 1: downstream read data strobe.
- `fifo_level` out LEVEL_W: number of storage entries occupied, excluding the output register. For debug.

## Operation
- Entry format is 13 bits: {ioreq, write, address[2:0], wdata[7:0]}. Reads are stored with wdata = 0.
- Storage is a circular buffer with write pointer, read pointer and count. Pointers wrap modulo DEPTH.
- `bus_ready = !full & !rd_pending`. Both terms are registered, so `bus_ready` does not depend combinationally on `bus_valid`.
- Acceptance of a read sets `rd_pending`. While `rd_pending` is 1, no further request is accepted, whether read or write.
- The output register loads the head entry when the register is empty, or when it is being consumed (`vdp_valid & vdp_ready`) in the same cycle.
- While `vdp_valid` is 1, every `vdp_*` request output holds stable until the handshake.
- On `vdp_rdata_en`, `bus_rdata <= vdp_rdata` and `bus_rdata_en <= 1` for exactly one cycle. `rd_pending` clears on that same edge.
- `vdp_rdata_en` while `rd_pending` is 0 is ignored: no strobe upstream, `bus_rdata` unchanged.
- Simultaneous push and pop are allowed and leave the count unchanged. Full is evaluated on the registered count, so a push is never accepted while full, even if a pop occurs the same cycle.
- Empty storage with an empty output register means `vdp_valid = 0`.
- Reset, including mid-transfer, clears storage, pointers, count, output register and `rd_pending`. The in-flight read is dropped and no `bus_rdata_en` is emitted for it.

## Timing
- Reset values: `bus_ready` = 1, `bus_rdata` = 8'h00, `bus_rdata_en` = 0, `vdp_valid` = 0, `vdp_address` = 0, `vdp_ioreq` = 0, `vdp_write` = 0, `vdp_wdata` = 0, `fifo_level` = 0.
- Forward latency with both buffers empty: request accepted in cycle N produces `vdp_valid` = 1 in cycle N+2.
- Throughput: one request per cycle in each direction when not stalled.
- Read-return latency: `vdp_rdata_en` in cycle M produces `bus_rdata_en` in cycle M+1.
- `bus_ready` falls in the cycle after the accepting edge when that push fills storage, or after a read is accepted.
- `bus_ready` rises in the cycle after the pop that makes storage non-full, or after `rd_pending` clears, whichever releases the last blocking condition.
- `fifo_level` updates one cycle after the push or pop that changes it.

## Structure
- Package `vdp_bus_pkg`: entry field positions (`ENT_WDATA` [7:0], `ENT_ADDR` [10:8], `ENT_WRITE` 11, `ENT_IOREQ` 12) and `ENT_W` = 13.
- One natural sub-module, `vdp_bus_fifo_mem`: a DEPTH×ENT_W register array with synchronous write and asynchronous read. Pointer, count and handshake logic stay in `vdp_bus_buffer`.
- Integration point: instantiate between `msx_slot` and `vdp` in the top level, both on `clk85m` with `reset_n`.

## Test plan
- Single write, DEPTH = 4: write addr 0, data 8'h5A in cycle N with `vdp_ready` = 1 -> `vdp_valid` = 1 in cycle N+2 with address 0, wdata 8'h5A, write = 1. `fifo_level` returns to 0.
- Fill with `vdp_ready` = 0: five back-to-back writes (8'h01–8'h05) -> `bus_ready` drops after the 5th is accepted, `fifo_level` = 4. After `vdp_ready` = 1, the downstream sees 8'h01–8'h05 in order, one per cycle.
- Read ordered behind writes: writes 8'h11 and 8'h22, then a read of addr 1 -> the read reaches `vdp` only after both writes. `bus_ready` = 0 until `vdp_rdata_en` with 8'hC3 arrives, then `bus_rdata_en` pulses once with `bus_rdata` = 8'hC3.
- Stray `vdp_rdata_en` with no pending read -> no `bus_rdata_en` pulse and `bus_rdata` unchanged.
- Wrap-around: 20 writes under random `vdp_ready` (50% duty) -> the data sequence at `vdp` exactly matches the input, and `fifo_level` never exceeds 4.
- Reset mid-operation: assert `reset_n` = 0 with three entries queued and a read pending -> all outputs take their reset values immediately, no request is issued after release, and `bus_ready` = 1 on the first cycle after release.
